// File: rtl/seq_digit_comparator_if.sv
// Operand/result bundle for seq_digit_comparator: operand handshake in, result handshake out.
// The master side sources operands and consumes results; the slave side is the comparator.
interface seq_digit_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int STAGES = WIDTH / DIGIT;
  localparam int IW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic             aEQb;
  logic             aLTb;
  logic             aGTb;
  logic [IW-1:0]    diff_digit;

  modport master (
    output in_valid, a, b, signed_mode, abort, out_ready,
    input  in_ready, out_valid, aEQb, aLTb, aGTb, diff_digit
  );

  modport slave (
    input  in_valid, a, b, signed_mode, abort, out_ready,
    output in_ready, out_valid, aEQb, aLTb, aGTb, diff_digit
  );
endinterface

// File: rtl/seq_digit_comparator.sv
// Iterative magnitude compare, DIGIT bits per cycle MSB first; latency accept + 1..WIDTH/DIGIT scan cycles.
// Result holds while out_ready is low; no new operands are accepted until the result is drained or aborted.
module seq_digit_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_digit_comparator_if.slave cmp
);
  localparam int STAGES = WIDTH / DIGIT;
  localparam int IW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  generate
    if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_width_chk
      $error("seq_digit_comparator: WIDTH must be a nonzero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [IW-1:0]    idx_q, idx_d, diff_q, diff_d;
  logic             aeq_q, aeq_d, alt_q, alt_d, agt_q, agt_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_mism, dig_gt, last_digit, accept;
  logic             in_ready_o, out_valid_o;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (idx_q == IW'(s)) begin
        dig_a = a_q[s*DIGIT +: DIGIT];
        dig_b = b_q[s*DIGIT +: DIGIT];
      end
    end
  end

  assign dig_mism   = (dig_a != dig_b);
  assign dig_gt     = (dig_a > dig_b);
  assign accept     = cmp.in_valid && !cmp.abort;
  // Only the first mismatch can trigger early exit; eq_q is still set on that digit.
  assign last_digit = (idx_q == '0) || (EARLY_EXIT && eq_q && dig_mism);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cmp.abort) state_d = IDLE;
               else if (last_digit) state_d = DONE;
      DONE:    if (cmp.abort || cmp.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    eq_d   = eq_q;
    lt_d   = lt_q;
    gt_d   = gt_q;
    idx_d  = idx_q;
    diff_d = diff_q;
    aeq_d  = aeq_q;
    alt_d  = alt_q;
    agt_d  = agt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d            = cmp.a;
          b_d            = cmp.b;
          a_d[WIDTH-1]   = cmp.a[WIDTH-1] ^ cmp.signed_mode;
          b_d[WIDTH-1]   = cmp.b[WIDTH-1] ^ cmp.signed_mode;
          eq_d           = 1'b1;
          lt_d           = 1'b0;
          gt_d           = 1'b0;
          idx_d          = IW'(STAGES - 1);
          diff_d         = '0;
          aeq_d          = 1'b0;
          alt_d          = 1'b0;
          agt_d          = 1'b0;
        end
      end
      RUN: begin
        if (cmp.abort) begin
          aeq_d  = 1'b0;
          alt_d  = 1'b0;
          agt_d  = 1'b0;
          diff_d = '0;
        end else begin
          if (eq_q && dig_mism) begin
            eq_d   = 1'b0;
            gt_d   = dig_gt;
            lt_d   = !dig_gt;
            diff_d = idx_q;
          end
          if (last_digit) begin
            aeq_d = eq_d;
            alt_d = lt_d;
            agt_d = gt_d;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (cmp.abort) begin
          aeq_d  = 1'b0;
          alt_d  = 1'b0;
          agt_d  = 1'b0;
          diff_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      idx_q  <= '0;
      diff_q <= '0;
      aeq_q  <= 1'b0;
      alt_q  <= 1'b0;
      agt_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      eq_q   <= eq_d;
      lt_q   <= lt_d;
      gt_q   <= gt_d;
      idx_q  <= idx_d;
      diff_q <= diff_d;
      aeq_q  <= aeq_d;
      alt_q  <= alt_d;
      agt_q  <= agt_d;
    end
  end

  assign cmp.in_ready   = in_ready_o;
  assign cmp.out_valid  = out_valid_o;
  assign cmp.aEQb       = aeq_q;
  assign cmp.aLTb       = alt_q;
  assign cmp.aGTb       = agt_q;
  assign cmp.diff_digit = diff_q;
endmodule
